// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with radix-4 Booth multiply and non-restoring divide.
// Define SEQ_ALU_DIV_EN to build the divider; without it op DIV completes as illegal.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero,
    output logic             illegal,
    output logic [2:0]       state_dbg
);

    localparam int SW = $clog2(WIDTH);
    localparam logic [SW-1:0] CNT_MUL = SW'(WIDTH / 2 - 1);
    localparam logic [SW-1:0] CNT_DIV = SW'(WIDTH - 1);

    localparam logic [4:0] OP_ADD   = 5'b00011;
    localparam logic [4:0] OP_SUB   = 5'b00100;
    localparam logic [4:0] OP_SHR   = 5'b00101;
    localparam logic [4:0] OP_SHRA  = 5'b00110;
    localparam logic [4:0] OP_SHL   = 5'b00111;
    localparam logic [4:0] OP_ROR   = 5'b01000;
    localparam logic [4:0] OP_ROL   = 5'b01001;
    localparam logic [4:0] OP_AND   = 5'b01010;
    localparam logic [4:0] OP_OR    = 5'b01011;
    localparam logic [4:0] OP_MUL   = 5'b01111;
    localparam logic [4:0] OP_DIV   = 5'b10000;
    localparam logic [4:0] OP_NEG   = 5'b10001;
    localparam logic [4:0] OP_NOT   = 5'b10010;
    localparam logic [4:0] OP_INCPC = 5'b10011;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_EXEC_MUL = 3'd1,
        S_EXEC_DIV = 3'd2,
        S_DIV_FIX  = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    // Handshake: a request is taken on a rising edge where start && !busy.
    // busy is high only while a multi-cycle op iterates; done is a one-cycle
    // pulse in which hi/lo/div_zero/illegal carry the new result. Start seen
    // while busy is dropped, and a new request may be taken in the done cycle.

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       hi_q, hi_d;
    logic [WIDTH-1:0]       lo_q, lo_d;
    logic                   div_zero_q, div_zero_d;
    logic                   illegal_q, illegal_d;
    logic [SW-1:0]          cnt_q, cnt_d;
    logic [2*WIDTH-1:0]     acc_q, acc_d;
    logic [2*WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH:0]         mplier_q, mplier_d;

    logic [WIDTH-1:0]       alu_hi, alu_lo;
    logic                   alu_dz, alu_ill;
    logic [SW-1:0]          rot_amt;
    logic [2*WIDTH-1:0]     rol_w, ror_w;
    logic [2*WIDTH-1:0]     booth_pp, acc_nx;

`ifdef SEQ_ALU_DIV_EN
    logic [WIDTH+1:0]       rem_q, rem_d;
    logic [WIDTH-1:0]       quo_q, quo_d;
    logic [WIDTH-1:0]       dvsr_q, dvsr_d;
    logic                   neg_quo_q, neg_quo_d;
    logic                   neg_rem_q, neg_rem_d;
    logic [WIDTH+1:0]       rem_sh, rem_nx, rem_fix;
    logic [WIDTH-1:0]       quo_nx, rem_mag, a_mag, b_mag;
`endif

    assign rot_amt = b[SW-1:0];

    // Single-cycle results, computed straight from the request inputs.
    always_comb begin
        alu_hi  = '0;
        alu_lo  = '0;
        alu_dz  = 1'b0;
        alu_ill = 1'b0;
        rol_w   = {a, a} << rot_amt;
        ror_w   = {a, a} >> rot_amt;
        case (op)
            OP_ADD:   alu_lo = a + b;
            OP_SUB:   alu_lo = a - b;
            OP_SHR:   alu_lo = a >> b;
            OP_SHRA:  alu_lo = $unsigned($signed(a) >>> b);
            OP_SHL:   alu_lo = a << b;
            OP_ROR:   alu_lo = ror_w[WIDTH-1:0];
            OP_ROL:   alu_lo = rol_w[2*WIDTH-1:WIDTH];
            OP_AND:   alu_lo = a & b;
            OP_OR:    alu_lo = a | b;
            OP_NEG:   alu_lo = -b;
            OP_NOT:   alu_lo = ~b;
            OP_INCPC: alu_lo = b + 1'b1;
            OP_MUL:   alu_ill = 1'b0;
`ifdef SEQ_ALU_DIV_EN
            OP_DIV: begin
                alu_lo = '1;
                alu_hi = a;
                alu_dz = 1'b1;
            end
`endif
            default:  alu_ill = 1'b1;
        endcase
    end

    // Booth digit from {b[2i+1], b[2i], b[2i-1]}; multiplicand pre-shifted by 2i.
    always_comb begin
        booth_pp = '0;
        case (mplier_q[2:0])
            3'b001, 3'b010: booth_pp = mcand_q;
            3'b011:         booth_pp = mcand_q << 1;
            3'b100:         booth_pp = -(mcand_q << 1);
            3'b101, 3'b110: booth_pp = -mcand_q;
            default:        booth_pp = '0;
        endcase
        acc_nx = acc_q + booth_pp;
    end

`ifdef SEQ_ALU_DIV_EN
    always_comb begin
        a_mag   = a[WIDTH-1] ? -a : a;
        b_mag   = b[WIDTH-1] ? -b : b;
        rem_sh  = {rem_q[WIDTH:0], quo_q[WIDTH-1]};
        rem_nx  = rem_q[WIDTH+1] ? rem_sh + {2'b00, dvsr_q} : rem_sh - {2'b00, dvsr_q};
        quo_nx  = {quo_q[WIDTH-2:0], ~rem_nx[WIDTH+1]};
        rem_fix = rem_q[WIDTH+1] ? rem_q + {2'b00, dvsr_q} : rem_q;
        rem_mag = rem_fix[WIDTH-1:0];
    end
`endif

    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = div_zero_q;
        illegal_d  = illegal_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
`ifdef SEQ_ALU_DIV_EN
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvsr_d     = dvsr_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
`endif
        busy       = (state_q == S_EXEC_MUL) || (state_q == S_EXEC_DIV) ||
                     (state_q == S_DIV_FIX);
        done       = (state_q == S_DONE);

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    if (op == OP_MUL) begin
                        state_d  = S_EXEC_MUL;
                        cnt_d    = CNT_MUL;
                        acc_d    = '0;
                        mcand_d  = {{WIDTH{a[WIDTH-1]}}, a};
                        mplier_d = {b, 1'b0};
`ifdef SEQ_ALU_DIV_EN
                    end else if ((op == OP_DIV) && (b != '0)) begin
                        state_d   = S_EXEC_DIV;
                        cnt_d     = CNT_DIV;
                        rem_d     = '0;
                        quo_d     = a_mag;
                        dvsr_d    = b_mag;
                        neg_quo_d = a[WIDTH-1] ^ b[WIDTH-1];
                        neg_rem_d = a[WIDTH-1];
`endif
                    end else begin
                        state_d    = S_DONE;
                        hi_d       = alu_hi;
                        lo_d       = alu_lo;
                        div_zero_d = alu_dz;
                        illegal_d  = alu_ill;
                    end
                end
            end
            S_EXEC_MUL: begin
                acc_d    = acc_nx;
                mcand_d  = mcand_q << 2;
                mplier_d = mplier_q >> 2;
                cnt_d    = cnt_q - SW'(1);
                if (cnt_q == '0) begin
                    state_d    = S_DONE;
                    hi_d       = acc_nx[2*WIDTH-1:WIDTH];
                    lo_d       = acc_nx[WIDTH-1:0];
                    div_zero_d = 1'b0;
                    illegal_d  = 1'b0;
                end
            end
`ifdef SEQ_ALU_DIV_EN
            S_EXEC_DIV: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                cnt_d = cnt_q - SW'(1);
                if (cnt_q == '0) begin
                    state_d = S_DIV_FIX;
                end
            end
            S_DIV_FIX: begin
                // Restore a negative final remainder, then apply operand signs.
                state_d    = S_DONE;
                hi_d       = neg_rem_q ? -rem_mag : rem_mag;
                lo_d       = neg_quo_q ? -quo_q : quo_q;
                div_zero_d = 1'b0;
                illegal_d  = 1'b0;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
            illegal_q  <= 1'b0;
            cnt_q      <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
            illegal_q  <= illegal_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
        end
    end

`ifdef SEQ_ALU_DIV_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end
`endif

    assign hi        = hi_q;
    assign lo        = lo_q;
    assign div_zero  = div_zero_q;
    assign illegal   = illegal_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: vector table plus handshake, back-to-back and reset sequences.
module tb_seq_alu;

  localparam int W = 32;

  localparam logic [4:0] OP_ADD   = 5'b00011;
  localparam logic [4:0] OP_SUB   = 5'b00100;
  localparam logic [4:0] OP_SHR   = 5'b00101;
  localparam logic [4:0] OP_SHRA  = 5'b00110;
  localparam logic [4:0] OP_SHL   = 5'b00111;
  localparam logic [4:0] OP_ROR   = 5'b01000;
  localparam logic [4:0] OP_ROL   = 5'b01001;
  localparam logic [4:0] OP_AND   = 5'b01010;
  localparam logic [4:0] OP_OR    = 5'b01011;
  localparam logic [4:0] OP_MUL   = 5'b01111;
  localparam logic [4:0] OP_DIV   = 5'b10000;
  localparam logic [4:0] OP_NEG   = 5'b10001;
  localparam logic [4:0] OP_NOT   = 5'b10010;
  localparam logic [4:0] OP_INCPC = 5'b10011;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [4:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] hi, lo;
  logic         div_zero, illegal;
  logic [2:0]   state_dbg;

  int errors;
  int checks;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    logic         ill;
    int           lat;
  } vec_t;

  vec_t vecs[$];

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo),
    .div_zero  (div_zero),
    .illegal   (illegal),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [4:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input logic [W-1:0] eh, input logic [W-1:0] el,
                         input logic edz, input logic eil, input int lat);
    vec_t v;
    v.op = o; v.a = aa; v.b = bb; v.hi = eh; v.lo = el; v.dz = edz; v.ill = eil; v.lat = lat;
    vecs.push_back(v);
  endtask

  // driver: issue one request, wait (bounded) for done, return what was seen
  task automatic run_op(input logic [4:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        output int lat, output logic [W-1:0] g_hi, output logic [W-1:0] g_lo,
                        output logic g_dz, output logic g_ill);
    @(negedge clk);
    start = 1'b1; op = o; a = aa; b = bb;
    @(posedge clk);
    #1;
    start = 1'b0; a = $urandom; b = $urandom; op = 5'($urandom_range(0, 31));
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      @(posedge clk);
      #1;
    end
    g_hi = hi; g_lo = lo; g_dz = div_zero; g_ill = illegal;
    if (lat == 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: op %b got no done within 100 cycles, expected done", o);
    end
  endtask

  initial begin
    int lat;
    logic [W-1:0] g_hi, g_lo;
    logic g_dz, g_ill;
    int done_cnt, first_done, second_done;
    logic [W-1:0] hi17, lo17, lo18;

    errors = 0;
    checks = 0;
    start = 1'b0; op = '0; a = '0; b = '0;
    rst_n = 1'b0;

    //            op        a             b             hi            lo            dz    ill   lat
    add_vec(OP_ADD,   32'h7FFFFFFF, 32'h00000001, 32'h0,        32'h80000000, 1'b0, 1'b0, 1);
    add_vec(OP_SUB,   32'h00000005, 32'h00000007, 32'h0,        32'hFFFFFFFE, 1'b0, 1'b0, 1);
    add_vec(OP_ADD,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'hFFFFFFFE, 1'b0, 1'b0, 1);
    add_vec(OP_MUL,   32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0, 17);
    add_vec(OP_MUL,   32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0, 17);
    add_vec(OP_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 1'b0, 17);
    add_vec(OP_MUL,   32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0, 1'b0, 17);
`ifdef SEQ_ALU_DIV_EN
    add_vec(OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0, 34);
    add_vec(OP_DIV,   32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1, 1'b0, 1);
    add_vec(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0, 34);
    add_vec(OP_DIV,   32'h00000064, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 1'b0, 1'b0, 34);
    add_vec(OP_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0, 1'b0, 34);
`else
    add_vec(OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'h0,        32'h0,        1'b0, 1'b1, 1);
    add_vec(OP_DIV,   32'h00000005, 32'h00000000, 32'h0,        32'h0,        1'b0, 1'b1, 1);
`endif
    add_vec(OP_SHRA,  32'h80000000, 32'd40,       32'h0,        32'hFFFFFFFF, 1'b0, 1'b0, 1);
    add_vec(OP_SHRA,  32'h40000000, 32'd40,       32'h0,        32'h00000000, 1'b0, 1'b0, 1);
    add_vec(OP_SHL,   32'h00000001, 32'd32,       32'h0,        32'h00000000, 1'b0, 1'b0, 1);
    add_vec(OP_SHR,   32'h80000000, 32'd4,        32'h0,        32'h08000000, 1'b0, 1'b0, 1);
    add_vec(OP_SHR,   32'h80000000, 32'd32,       32'h0,        32'h00000000, 1'b0, 1'b0, 1);
    add_vec(OP_ROL,   32'h80000001, 32'd33,       32'h0,        32'h00000003, 1'b0, 1'b0, 1);
    add_vec(OP_ROL,   32'h12345678, 32'd4,        32'h0,        32'h23456781, 1'b0, 1'b0, 1);
    add_vec(OP_ROR,   32'h00000001, 32'd1,        32'h0,        32'h80000000, 1'b0, 1'b0, 1);
    add_vec(OP_AND,   32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,        32'h00F000F0, 1'b0, 1'b0, 1);
    add_vec(OP_OR,    32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,        32'hFFF0FFF0, 1'b0, 1'b0, 1);
    add_vec(OP_NEG,   32'h00001234, 32'h00000005, 32'h0,        32'hFFFFFFFB, 1'b0, 1'b0, 1);
    add_vec(OP_NOT,   32'h00001234, 32'h0000FFFF, 32'h0,        32'hFFFF0000, 1'b0, 1'b0, 1);
    add_vec(OP_INCPC, 32'h00001234, 32'hFFFFFFFF, 32'h0,        32'h00000000, 1'b0, 1'b0, 1);
    add_vec(5'b00000, 32'h00000001, 32'h00000002, 32'h0,        32'h00000000, 1'b0, 1'b1, 1);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_dz", 64'(div_zero), 64'd0);
    chk("rst_ill", 64'(illegal), 64'd0);
    chk("rst_state", 64'(state_dbg), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      exp_q.push_back(vecs[i].lo);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, g_hi, g_lo, g_dz, g_ill);
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("vec%0d_lo", i), 64'(g_lo), 64'(exp_q.pop_front()));
      chk($sformatf("vec%0d_hi", i), 64'(g_hi), 64'(vecs[i].hi));
      chk($sformatf("vec%0d_dz", i), 64'(g_dz), 64'(vecs[i].dz));
      chk($sformatf("vec%0d_ill", i), 64'(g_ill), 64'(vecs[i].ill));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_done_drop", i), 64'(done), 64'd0);
      chk($sformatf("vec%0d_hold_lo", i), 64'(lo), 64'(vecs[i].lo));
    end

    // MUL with ignored ADD at cycle 5, then ADD issued in the done cycle
    @(negedge clk);
    start = 1'b1; op = OP_MUL; a = 32'hFFFFFFFD; b = 32'h00000007;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_busy_c1", 64'(busy), 64'd1);
    done_cnt = 0; first_done = 0; second_done = 0;
    hi17 = '0; lo17 = '0; lo18 = '0;
    for (int k = 1; k <= 18; k++) begin
      if (done) begin
        done_cnt++;
        if (first_done == 0) first_done = k;
        else second_done = k;
        if (k == 17) begin hi17 = hi; lo17 = lo; end
        if (k == 18) lo18 = lo;
      end
      @(negedge clk);
      if (k == 5) begin
        start = 1'b1; op = OP_ADD; a = 32'd100; b = 32'd1;
      end else if (k == 17) begin
        start = 1'b1; op = OP_ADD; a = 32'd2; b = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    chk("b2b_done_count", 64'(done_cnt), 64'd2);
    chk("b2b_first_done", 64'(first_done), 64'd17);
    chk("b2b_second_done", 64'(second_done), 64'd18);
    chk("b2b_mul_hi", 64'(hi17), 64'hFFFFFFFF);
    chk("b2b_mul_lo", 64'(lo17), 64'hFFFFFFEB);
    chk("b2b_add_lo", 64'(lo18), 64'd5);

    // reset in cycle 8 of a divide
    @(negedge clk);
    start = 1'b1; op = OP_DIV; a = 32'hFFFFFFF9; b = 32'h00000002;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_hi", 64'(hi), 64'd0);
    chk("midrst_lo", 64'(lo), 64'd0);
    chk("midrst_dz_ill", 64'({div_zero, illegal}), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    chk("midrst_no_done", 64'(done_cnt), 64'd0);
    run_op(OP_ADD, 32'd2, 32'd2, lat, g_hi, g_lo, g_dz, g_ill);
    chk("postrst_lat", 64'(lat), 64'd1);
    chk("postrst_lo", 64'(g_lo), 64'd4);
    chk("postrst_hi", 64'(g_hi), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
